user_word_seq: RTL
==================

# user_word_seq

Sequencer that owns the user-word count decoder path: on a start request it captures the emulation mode, `cfg` and `page`, and resolves the user word count. It then issues that many word-read beats over a valid/ready handshake toward the user-word buffer, with a done pulse at the end. It sits between the mode/config register block and the user-word buffer read port.

## Interface
- `ADDR_W`, 16: width of the word address output.
- `WORD_STRIDE`, 4: address increment per beat, an unsigned constant.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sequence; sampled only in IDLE.
- `is_su_mode`, `is_em_emul`, `is_ata_emul`  in  1 each  mode flags, captured on accepted start.
- `page`  in  1  page select, captured on accepted start.
- `cfg`  in  7  configuration, captured on accepted start.
- `base_addr`  in  ADDR_W  first word address, captured on accepted start.
- `abort`  in  1  cancel the sequence in progress (only with `USER_WORD_SEQ_ABORT_EN`).
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer ready.
- `out_addr`  out  ADDR_W  beat address.
- `out_index`  out  4  beat number, 0-based.
- `out_last`  out  1  high with the final beat.
- `word_count`  out  4  resolved count, held until the next accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, XFER, DONE.
- IDLE: when `start`=1, capture all inputs and go to LOAD.
- LOAD: register the resolved count into `word_count`. If the count is 0, go to DONE; otherwise go to XFER with index 0.
- Count resolution, in priority order:
  - `is_su_mode` → 0.
  - else `is_em_emul`: `cfg[3:0]` in 5..13 gives `cfg[3:0]`−5 (0..8); any other value gives 3.
  - else `is_ata_emul`: `cfg[6:4]` of 0 or 1 gives 0; 2 gives 1; 3 gives 2; 4..7 gives 2 if `page`=1, else `cfg[6:4]`−1 (3..6).
  - else → 0.
- XFER:
  - `out_valid`=1.
  - `out_addr` = captured base + index×`WORD_STRIDE`, truncated to ADDR_W so it wraps modulo 2^ADDR_W.
  - `out_last` = (index == count−1).
  - A beat completes when `out_valid`&`out_ready`. On completion, increment index, or go to DONE if it was the last beat.
  - `out_addr`, `out_index` and `out_last` stay stable while valid is high and ready is low.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` in LOAD, XFER or DONE is ignored and not queued.
- Reset values: state IDLE, `out_valid`=0, `out_addr`=0, `out_index`=0, `out_last`=0, `word_count`=0, `busy`=0, `done`=0.
- `rst` asserted in any state returns the block to IDLE with the reset values on the next edge. No `done` pulse is produced and any beat in flight is dropped.

## Timing
- `start` sampled at edge N → `busy`=1 after N. `word_count` valid after N+1. First `out_valid` after N+1 for a nonzero count.
- Zero count: `done` is high for the cycle after N+1, and `busy` drops after N+2.
- Back-to-back beats: with `out_ready` held at 1, one beat per cycle.
- Final handshake at edge M → `done` high in cycle M..M+1. `start` is accepted again at edge M+2.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`.

## Configuration
- `USER_WORD_SEQ_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in LOAD or XFER → DONE on the next edge with `done` pulsed. Any beat not yet handshaken is discarded.
  - `abort` takes priority over a simultaneous handshake; that beat is not counted as transferred.
  - In IDLE and DONE, `abort` is ignored.
- Undefined: no `abort` port and no abort logic; a sequence always runs to completion.

## Test plan
- Reset mid-XFER (count 5, index 2) → next cycle: `busy`=0, `out_valid`=0, `word_count`=0, no `done` pulse.
- `is_em_emul`=1, `cfg`=7'h06, `base_addr`=16'h0100, `out_ready`=1 → `word_count`=1. One beat: addr 16'h0100, index 0, `out_last`=1. `done` 2 cycles after the handshake-free start+2 timing described above.
- `is_ata_emul`=1, `cfg`=7'h60, `page`=0, `out_ready` toggling 1/0 → `word_count`=5. Addresses base+0,4,8,12,16, held stable during stalls; `out_last` only on index 4.
- Same as above with `page`=1 → `word_count`=2. `is_su_mode`=1 with any `cfg` → count 0, `done` one cycle after LOAD, no `out_valid`.
- `base_addr`=16'hFFFC, `is_em_emul`=1, `cfg`=7'h08 (count 3) → addresses FFFC, 0000, 0004 (wrap). `start` pulsed during XFER is ignored.
- With `USER_WORD_SEQ_ABORT_EN`: count 6, `abort` at index 3 together with a handshake → `done` next cycle, only beats 0..2 counted, `out_valid`=0.

Source files
------------

// File: rtl/user_word_seq.sv
// User-word count sequencer: resolves a word count from mode/cfg/page and issues word-read beats.
// Optional abort support is compiled in with `define USER_WORD_SEQ_ABORT_EN.
module user_word_seq #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WORD_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_su_mode,
    input  logic              is_em_emul,
    input  logic              is_ata_emul,
    input  logic              page,
    input  logic [6:0]        cfg,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef USER_WORD_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        out_index,
    output logic              out_last,
    output logic [3:0]        word_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StLoad, StXfer, StDone} state_e;

    state_e state_q, state_d;

    logic              su_q, em_q, ata_q, page_q;
    logic              su_d, em_d, ata_d, page_d;
    logic [6:0]        cfg_q, cfg_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [3:0]        out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic [3:0]        word_count_q, word_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              abort_w;
    logic              beat_hs;
    logic [3:0]        count_res;

`ifdef USER_WORD_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign beat_hs = out_valid_q & out_ready;

    // Count resolution from the captured mode flags, in priority order.
    always_comb begin
        count_res = 4'd0;
        if (su_q) begin
            count_res = 4'd0;
        end else if (em_q) begin
            if (cfg_q[3:0] >= 4'd5 && cfg_q[3:0] <= 4'd13) begin
                count_res = cfg_q[3:0] - 4'd5;
            end else begin
                count_res = 4'd3;
            end
        end else if (ata_q) begin
            unique case (cfg_q[6:4])
                3'd0, 3'd1: count_res = 4'd0;
                3'd2:       count_res = 4'd1;
                3'd3:       count_res = 4'd2;
                default:    count_res = page_q ? 4'd2 : {1'b0, cfg_q[6:4] - 3'd1};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            su_q         <= 1'b0;
            em_q         <= 1'b0;
            ata_q        <= 1'b0;
            page_q       <= 1'b0;
            cfg_q        <= '0;
            base_q       <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            su_q         <= su_d;
            em_q         <= em_d;
            ata_q        <= ata_d;
            page_q       <= page_d;
            cfg_q        <= cfg_d;
            base_q       <= base_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            word_count_q <= word_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLoad;
            StLoad: begin
                if (abort_w || count_res == 4'd0) state_d = StDone;
                else                              state_d = StXfer;
            end
            StXfer: begin
                if (abort_w || (beat_hs && out_last_q)) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        su_d         = su_q;
        em_d         = em_q;
        ata_d        = ata_q;
        page_d       = page_q;
        cfg_d        = cfg_q;
        base_d       = base_q;
        out_addr_d   = out_addr_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        word_count_d = word_count_q;
        out_valid_d  = (state_d == StXfer);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    su_d   = is_su_mode;
                    em_d   = is_em_emul;
                    ata_d  = is_ata_emul;
                    page_d = page;
                    cfg_d  = cfg;
                    base_d = base_addr;
                end
            end
            StLoad: begin
                word_count_d = count_res;
                out_index_d  = 4'd0;
                out_addr_d   = base_q;
                out_last_d   = (count_res == 4'd1);
            end
            StXfer: begin
                if (beat_hs && !out_last_q && !abort_w) begin
                    out_index_d = out_index_q + 4'd1;
                    out_addr_d  = out_addr_q + ADDR_W'(WORD_STRIDE);
                    out_last_d  = ((out_index_q + 4'd1) == (word_count_q - 4'd1));
                end
            end
            default: ;
        endcase

        if (state_d != StXfer) out_last_d = 1'b0;
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_index  = out_index_q;
    assign out_last   = out_last_q;
    assign word_count = word_count_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
